rv32i_fetch: RTL

- Instruction fetch unit for the RV32I soft core; the upstream producer of the decoder's `instr`/`pc_in` stream.
- Issues word reads to instruction memory over a wait-request / read-data-valid bus and buffers responses in a small prefetch FIFO.
- Presents one {instr, pc} pair per cycle, held while `stall` is high.
- On `update_pc`, flushes all in-flight and buffered fetches and redirects to the new PC.

---
 rtl/rv32i_fetch_pkg.sv | 17 +
 rtl/rv32i_fetch_fifo.sv | 46 ++++
 rtl/rv32i_fetch.sv | 135 +++++++++++++
 3 files changed

// File: rtl/rv32i_fetch_pkg.sv
// rtl/rv32i_fetch_pkg.sv - shared RV32I constants and the fetch entry type
package rv32i_fetch_pkg;

   localparam logic [31:0] RV32I_NOP                  = 32'h0000_0013;
   localparam logic [31:0] RV32I_RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] RV32I_TRAP_VECTOR_DEFAULT  = 32'h0000_0040;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// rtl/rv32i_fetch_fifo.sv - prefetch FIFO; flush wins over push/pop in the same cycle
module rv32i_fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [$clog2(DEPTH):0]   count,
   output logic [WIDTH-1:0]         head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/rv32i_fetch.sv
// rtl/rv32i_fetch.sv - RV32I instruction fetch with prefetch FIFO and redirect flush
// Optional misaligned-redirect trap: RV32I_FETCH_MISALIGN_TRAP_EN
module rv32i_fetch
   import rv32i_fetch_pkg::*;
#(
   parameter logic [31:0] RV32I_RESET_VECTOR    = RV32I_RESET_VECTOR_DEFAULT,
   parameter int          RV32I_FETCH_DEPTH     = 4,
   parameter int          RV32I_MAX_OUTSTANDING = 2
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
   ,
   parameter logic [31:0] RV32I_TRAP_VECTOR     = RV32I_TRAP_VECTOR_DEFAULT
`endif
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] iaddress,
   output logic        iread,
   input  logic        iwaitrequest,
   input  logic [31:0] ireaddata,
   input  logic        ireaddatavalid,
   input  logic        stall,
   input  logic        update_pc,
   input  logic [31:0] new_pc,
   output logic [31:0] instr,
   output logic [31:0] pc
`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
   ,
   output logic        misaligned
`endif
);

   localparam int CW = $clog2(RV32I_FETCH_DEPTH) + 1;
   localparam int OW = $clog2(RV32I_MAX_OUTSTANDING + 1);
   localparam int SW = ((CW > OW) ? CW : OW) + 1;

   logic [31:0]   fetch_pc;
   logic [31:0]   ret_pc;
   logic [31:0]   redirect_pc;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] discard;
   logic [CW-1:0] fifo_count;
   logic [SW-1:0] occupancy;
   fetch_entry_t  fifo_head;
   fetch_entry_t  push_entry;
   logic          accept;
   logic          resp_valid;
   logic          keep;
   logic          pop;
   logic          fifo_empty;

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
   logic misalign_req;
   assign misalign_req = |new_pc[1:0];
   assign redirect_pc  = misalign_req ? word_align(RV32I_TRAP_VECTOR) : word_align(new_pc);
`else
   assign redirect_pc  = word_align(new_pc);
`endif

   // Counting buffered plus in-flight words guarantees every response has a FIFO slot.
   assign occupancy  = SW'(fifo_count) + SW'(outstanding);
   assign iread      = reset_n && !update_pc
                       && (occupancy < SW'(RV32I_FETCH_DEPTH))
                       && (outstanding < OW'(RV32I_MAX_OUTSTANDING));
   assign iaddress   = fetch_pc;
   assign accept     = iread && !iwaitrequest;
   assign resp_valid = ireaddatavalid && (outstanding != '0);
   assign keep       = resp_valid && (discard == '0) && !update_pc;
   assign fifo_empty = (fifo_count == '0);
   assign pop        = !stall && !fifo_empty && !update_pc;
   assign push_entry = '{pc: ret_pc, instr: ireaddata};

   rv32i_fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (RV32I_FETCH_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (keep),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (update_pc),
      .count     (fifo_count),
      .head      (fifo_head)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fetch_pc    <= RV32I_RESET_VECTOR;
         ret_pc      <= RV32I_RESET_VECTOR;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         if (update_pc) begin
            fetch_pc <= redirect_pc;
            ret_pc   <= redirect_pc;
         end else begin
            if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (keep)   ret_pc   <= ret_pc + 32'd4;
         end
         outstanding <= outstanding + OW'(accept) - OW'(resp_valid);
         // A response landing in the redirect cycle is already dropped, so it is not counted.
         if (update_pc)
            discard <= outstanding - OW'(resp_valid);
         else if (resp_valid && (discard != '0))
            discard <= discard - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         instr <= RV32I_NOP;
         pc    <= RV32I_RESET_VECTOR;
      end else if (update_pc) begin
         instr <= RV32I_NOP;
         pc    <= new_pc;
      end else if (!stall) begin
         if (!fifo_empty) begin
            instr <= fifo_head.instr;
            pc    <= fifo_head.pc;
         end else begin
            instr <= RV32I_NOP;
         end
      end
   end

`ifdef RV32I_FETCH_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (!reset_n)
         misaligned <= 1'b0;
      else
         misaligned <= update_pc && misalign_req;
   end
`endif

endmodule
